// File: rtl/h14tx_clk_rst_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : h14tx_clk_rst_ctrl_if
// Description : PLL lock / link reset signal bundle for h14tx_clk_rst_ctrl.
//               Optional lock_loss_cnt member under H14TX_CLK_RST_LOSS_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
interface h14tx_clk_rst_ctrl_if #(
    parameter int MAX_RETRIES = 8
) ();
    localparam int c_retry_w = $clog2(MAX_RETRIES + 1) + 1;

    logic                 pll_lock;
    logic                 pll_rst_n;
    logic                 link_rst;
    logic                 link_ready;
    logic                 pll_fail;
    logic [c_retry_w-1:0] retry_cnt;
`ifdef H14TX_CLK_RST_LOSS_CNT_EN
    logic [7:0]           lock_loss_cnt;

    modport master (
        input  pll_lock,
        output pll_rst_n, link_rst, link_ready, pll_fail, retry_cnt, lock_loss_cnt
    );
    modport slave (
        output pll_lock,
        input  pll_rst_n, link_rst, link_ready, pll_fail, retry_cnt, lock_loss_cnt
    );
`else
    modport master (
        input  pll_lock,
        output pll_rst_n, link_rst, link_ready, pll_fail, retry_cnt
    );
    modport slave (
        output pll_lock,
        input  pll_rst_n, link_rst, link_ready, pll_fail, retry_cnt
    );
`endif
endinterface
`default_nettype wire

// File: rtl/h14tx_clk_rst_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : h14tx_clk_rst_ctrl
// Description : HDMI TX PLL reset/lock supervisor with bounded retries.
//               Optional RUN lock-loss counter: H14TX_CLK_RST_LOSS_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module h14tx_clk_rst_ctrl #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 70000,
    parameter int STABLE_CYCLES       = 7000,
    parameter int MAX_RETRIES         = 8
) (
    input  wire                  ref_clk_70mhz,
    input  wire                  rst,
    h14tx_clk_rst_ctrl_if.master bus
);
    localparam int c_retry_w = $clog2(MAX_RETRIES + 1) + 1;
    localparam int c_max_ab  = (LOCK_TIMEOUT_CYCLES > STABLE_CYCLES) ? LOCK_TIMEOUT_CYCLES : STABLE_CYCLES;
    localparam int c_cnt_max = (c_max_ab > PLL_RST_CYCLES) ? c_max_ab : PLL_RST_CYCLES;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

    localparam logic [c_cnt_w-1:0]   c_pll_last     = c_cnt_w'(PLL_RST_CYCLES - 1);
    localparam logic [c_cnt_w-1:0]   c_timeout_last = c_cnt_w'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0]   c_stable_last  = c_cnt_w'(STABLE_CYCLES - 1);
    localparam logic [c_retry_w-1:0] c_max_retries  = c_retry_w'(MAX_RETRIES);
    localparam logic [c_retry_w-1:0] c_retry_sat    = c_retry_w'(MAX_RETRIES + 1);

    localparam logic [2:0] c_st_pll_rst   = 3'd0;
    localparam logic [2:0] c_st_wait_lock = 3'd1;
    localparam logic [2:0] c_st_stabilize = 3'd2;
    localparam logic [2:0] c_st_run       = 3'd3;
    localparam logic [2:0] c_st_fail      = 3'd4;

    logic                 r_lock_meta;
    logic                 r_lock_s;
    logic [2:0]           r_state;
    logic [2:0]           w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic [c_retry_w-1:0] r_retry_cnt;
    logic [c_retry_w-1:0] w_retry_nxt;
    logic                 r_pll_rst_n;
    logic                 r_link_rst;
    logic                 r_link_ready;
    logic                 r_pll_fail;
    logic                 w_pll_rst_n;
    logic                 w_link_rst;
    logic                 w_link_ready;
    logic                 w_pll_fail;

    // State, counter and output flops; outputs are decoded from the next state
    // so they change on the same edge as the state register.
    always_ff @(posedge ref_clk_70mhz) begin
        if (rst) begin
            r_lock_meta  <= 1'b0;
            r_lock_s     <= 1'b0;
            r_state      <= c_st_pll_rst;
            r_cnt        <= '0;
            r_retry_cnt  <= '0;
            r_pll_rst_n  <= 1'b0;
            r_link_rst   <= 1'b1;
            r_link_ready <= 1'b0;
            r_pll_fail   <= 1'b0;
        end else begin
            r_lock_meta  <= bus.pll_lock;
            r_lock_s     <= r_lock_meta;
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_retry_cnt  <= w_retry_nxt;
            r_pll_rst_n  <= w_pll_rst_n;
            r_link_rst   <= w_link_rst;
            r_link_ready <= w_link_ready;
            r_pll_fail   <= w_pll_fail;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_retry_nxt = r_retry_cnt;
        case (r_state)
            c_st_pll_rst: begin
                if (r_cnt == c_pll_last) begin
                    w_state_nxt = c_st_wait_lock;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            c_st_wait_lock: begin
                // Lock takes priority over a timeout landing on the same cycle.
                if (r_lock_s) begin
                    w_state_nxt = c_st_stabilize;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_timeout_last) begin
                    w_cnt_nxt = '0;
                    if (r_retry_cnt < c_max_retries) begin
                        w_retry_nxt = r_retry_cnt + 1'b1;
                        w_state_nxt = c_st_pll_rst;
                    end else begin
                        w_state_nxt = c_st_fail;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            c_st_stabilize: begin
                if (!r_lock_s) begin
                    w_state_nxt = c_st_wait_lock;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_stable_last) begin
                    w_state_nxt = c_st_run;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            c_st_run: begin
                if (!r_lock_s) begin
                    w_state_nxt = c_st_pll_rst;
                    w_cnt_nxt   = '0;
                    if (r_retry_cnt != c_retry_sat) begin
                        w_retry_nxt = r_retry_cnt + 1'b1;
                    end
                end
            end
            c_st_fail: begin
                w_state_nxt = c_st_fail;
            end
            default: begin
                w_state_nxt = c_st_pll_rst;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_pll_rst_n  = 1'b1;
        w_link_rst   = 1'b1;
        w_link_ready = 1'b0;
        w_pll_fail   = 1'b0;
        case (w_state_nxt)
            c_st_pll_rst: w_pll_rst_n = 1'b0;
            c_st_run: begin
                w_link_rst   = 1'b0;
                w_link_ready = 1'b1;
            end
            c_st_fail: begin
                w_pll_rst_n = 1'b0;
                w_pll_fail  = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.pll_rst_n  = r_pll_rst_n;
    assign bus.link_rst   = r_link_rst;
    assign bus.link_ready = r_link_ready;
    assign bus.pll_fail   = r_pll_fail;
    assign bus.retry_cnt  = r_retry_cnt;

`ifdef H14TX_CLK_RST_LOSS_CNT_EN
    logic [7:0] r_lock_loss_cnt;

    always_ff @(posedge ref_clk_70mhz) begin
        if (rst) begin
            r_lock_loss_cnt <= 8'd0;
        end else if ((r_state == c_st_run) && !r_lock_s && (r_lock_loss_cnt != 8'hFF)) begin
            r_lock_loss_cnt <= r_lock_loss_cnt + 8'd1;
        end
    end

    assign bus.lock_loss_cnt = r_lock_loss_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_h14tx_clk_rst_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_h14tx_clk_rst_ctrl
// Description : Directed bench for h14tx_clk_rst_ctrl (PLL=4, TO=50, ST=20, MR=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_h14tx_clk_rst_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    h14tx_clk_rst_ctrl_if #(.MAX_RETRIES(2)) bus ();

    h14tx_clk_rst_ctrl #(
        .PLL_RST_CYCLES      (4),
        .LOCK_TIMEOUT_CYCLES (50),
        .STABLE_CYCLES       (20),
        .MAX_RETRIES         (2)
    ) dut (
        .ref_clk_70mhz (clk),
        .rst           (rst),
        .bus           (bus)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst          = 1'b1;
        bus.pll_lock = 1'b0;
        tick(3);
        check("rst_pll_rst_n",  32'(bus.pll_rst_n),  0);
        check("rst_link_rst",   32'(bus.link_rst),   1);
        check("rst_link_ready", 32'(bus.link_ready), 0);
        check("rst_pll_fail",   32'(bus.pll_fail),   0);
        check("rst_retry_cnt",  32'(bus.retry_cnt),  0);

        // Nominal bring-up: 4-cycle PLL reset, lock raised, 2+20 cycles to RUN
        rst = 1'b0;
        tick(3);
        check("bup_pulse_low", 32'(bus.pll_rst_n), 0);
        tick(1);
        check("bup_pulse_end", 32'(bus.pll_rst_n), 1);
        tick(6);
        bus.pll_lock = 1'b1;
        tick(22);
        check("bup_link_rst_hold", 32'(bus.link_rst), 1);
        tick(1);
        check("bup_link_rst_rel", 32'(bus.link_rst),   0);
        check("bup_link_ready",   32'(bus.link_ready), 1);
        check("bup_retry_cnt",    32'(bus.retry_cnt),  0);

        // Lock loss in RUN: link reset reasserted on the third edge
        bus.pll_lock = 1'b0;
        tick(2);
        check("loss_early", 32'(bus.link_rst), 0);
        tick(1);
        check("loss_link_rst",   32'(bus.link_rst),   1);
        check("loss_link_ready", 32'(bus.link_ready), 0);
        check("loss_pll_rst_n",  32'(bus.pll_rst_n),  0);
        check("loss_retry_cnt",  32'(bus.retry_cnt),  1);
`ifdef H14TX_CLK_RST_LOSS_CNT_EN
        check("loss_lock_loss_cnt", 32'(bus.lock_loss_cnt), 1);
`endif
        tick(3);
        check("loss_pulse_low", 32'(bus.pll_rst_n), 0);
        tick(1);
        check("loss_pulse_end", 32'(bus.pll_rst_n), 1);

        // Glitch during STABILIZE: 10 high, 3 low, then high again
        bus.pll_lock = 1'b1;
        tick(10);
        bus.pll_lock = 1'b0;
        tick(3);
        bus.pll_lock = 1'b1;
        check("glitch_link_rst_a", 32'(bus.link_rst), 1);
        tick(22);
        check("glitch_link_rst_b", 32'(bus.link_rst), 1);
        tick(1);
        check("glitch_link_rst_rel", 32'(bus.link_rst),   0);
        check("glitch_link_ready",   32'(bus.link_ready), 1);
        check("glitch_retry_cnt",    32'(bus.retry_cnt),  1);

        // Second loss, then lock_s arrives on the last WAIT_LOCK cycle
        bus.pll_lock = 1'b0;
        tick(3);
        check("sim_retry_pre", 32'(bus.retry_cnt), 2);
        tick(4);
        check("sim_wait_entry", 32'(bus.pll_rst_n), 1);
        tick(47);
        bus.pll_lock = 1'b1;
        tick(2);
        check("sim_cnt48", 32'(bus.pll_rst_n), 1);
        tick(1);
        check("sim_pll_rst_n", 32'(bus.pll_rst_n), 1);
        check("sim_pll_fail",  32'(bus.pll_fail),  0);
        check("sim_link_rst",  32'(bus.link_rst),  1);
        check("sim_retry_cnt", 32'(bus.retry_cnt), 2);

        // Reset for one cycle while in STABILIZE
        tick(5);
        check("mid_stab_link_rst", 32'(bus.link_rst), 1);
        rst          = 1'b1;
        bus.pll_lock = 1'b0;
        tick(1);
        check("mid_pll_rst_n",  32'(bus.pll_rst_n),  0);
        check("mid_link_rst",   32'(bus.link_rst),   1);
        check("mid_link_ready", 32'(bus.link_ready), 0);
        check("mid_pll_fail",   32'(bus.pll_fail),   0);
        check("mid_retry_cnt",  32'(bus.retry_cnt),  0);
        rst = 1'b0;
        tick(3);
        check("mid_pulse_low", 32'(bus.pll_rst_n), 0);
        tick(1);
        check("mid_pulse_end", 32'(bus.pll_rst_n), 1);

        // Timeouts with lock held low: retry 1, retry 2, then FAIL
        tick(49);
        check("to1_wait_end", 32'(bus.pll_rst_n), 1);
        check("to1_retry_pre", 32'(bus.retry_cnt), 0);
        tick(1);
        check("to1_pll_rst_n", 32'(bus.pll_rst_n), 0);
        check("to1_retry_cnt", 32'(bus.retry_cnt), 1);
        tick(3);
        check("to1_pulse_low", 32'(bus.pll_rst_n), 0);
        tick(1);
        check("to1_pulse_end", 32'(bus.pll_rst_n), 1);
        tick(49);
        check("to2_wait_end", 32'(bus.pll_rst_n), 1);
        tick(1);
        check("to2_pll_rst_n", 32'(bus.pll_rst_n), 0);
        check("to2_retry_cnt", 32'(bus.retry_cnt), 2);
        tick(4);
        check("to2_pulse_end", 32'(bus.pll_rst_n), 1);
        tick(49);
        check("to3_no_fail_yet", 32'(bus.pll_fail), 0);
        tick(1);
        check("fail_pll_fail",   32'(bus.pll_fail),   1);
        check("fail_pll_rst_n",  32'(bus.pll_rst_n),  0);
        check("fail_link_rst",   32'(bus.link_rst),   1);
        check("fail_link_ready", 32'(bus.link_ready), 0);
        check("fail_retry_cnt",  32'(bus.retry_cnt),  2);
        bus.pll_lock = 1'b1;
        tick(40);
        check("fail_stuck_fail",  32'(bus.pll_fail),  1);
        check("fail_stuck_rst_n", 32'(bus.pll_rst_n), 0);
        check("fail_stuck_link",  32'(bus.link_rst),  1);
        rst = 1'b1;
        tick(1);
        check("fail_cleared",    32'(bus.pll_fail),  0);
        check("fail_retry_clr",  32'(bus.retry_cnt), 0);
        rst = 1'b0;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
